// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: merges the unstallable pipeline writeback (A) with a
// one-entry buffered long-latency result (B), and tracks pending long-op destinations.
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  input  logic        issue_valid,
  input  logic        issue_long,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        hazard_stall,
  output logic        pipe_hold,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_req_t;

  logic          buf_valid;
  wb_req_t       buf_q;
  logic [31:0]   pending;
  logic [CW-1:0] wait_cnt;

  logic          a_wr, buf_wr, b_fire, issue_set;
  logic [31:0]   set_mask, clr_mask;

  assign b_ready = !buf_valid && !reset;
  assign b_fire  = b_valid && b_ready;
  assign a_wr    = a_valid && (a_addr != 5'd0);
  // Buffer only drains when A is idle; reset suppresses the drain so a discarded result never lands.
  assign buf_wr  = buf_valid && !a_wr && !reset;

  always_comb begin
    rf_we    = a_wr || buf_wr;
    rf_waddr = a_wr ? a_addr : buf_q.addr;
    rf_wdata = a_wr ? a_data : buf_q.data;
  end

  assign hazard_stall = issue_valid &&
                        (pending[rs1_addr] || pending[rs2_addr] || (issue_long && pending[issue_rd]));
  assign issue_set    = issue_valid && !hazard_stall && issue_long && (issue_rd != 5'd0);
  assign set_mask     = 32'(issue_set) << issue_rd;
  assign clr_mask     = 32'(buf_wr) << buf_q.addr;
  assign pipe_hold    = buf_valid && (wait_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_q     <= '0;
      pending   <= '0;
      wait_cnt  <= '0;
    end else begin
      if (buf_wr) begin
        buf_valid <= 1'b0;
      end else if (b_fire && (b_addr != 5'd0)) begin
        buf_valid <= 1'b1;
        buf_q     <= '{addr: b_addr, data: b_data};
      end
      // Set is applied after clear so an issue to the register being retired stays pending.
      pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
      if (buf_wr)
        wait_cnt <= '0;
      else if (buf_valid && a_wr && (wait_cnt != CNT_MAX))
        wait_cnt <= wait_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_rf_wb_arbiter;
  localparam int LIMIT = 4;

  logic        clk, reset;
  logic        a_valid, b_valid, b_ready, issue_valid, issue_long;
  logic [4:0]  a_addr, b_addr, issue_rd, rs1_addr, rs2_addr, rf_waddr;
  logic [31:0] a_data, b_data, rf_wdata;
  logic        hazard_stall, pipe_hold, rf_we;

  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .hazard_stall(hazard_stall), .pipe_hold(pipe_hold),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file fed by the write port, used for read-after-write checks.
  logic [31:0] rf_mem [32];
  always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;

  int chk_total = 0;
  int chk_pass  = 0;

  // Reference model: pending set, FIFO of buffered results, and a starvation counter.
  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t       m_bq[$];
  bit [31:0] m_pend;
  int        m_wcnt;

  function automatic bit m_stall();
    return issue_valid && (m_pend[rs1_addr] || m_pend[rs2_addr] || (issue_long && m_pend[issue_rd]));
  endfunction

  task automatic model_step();
    bit aw, bwr, bacc, hz;
    aw = a_valid && a_addr != 0;
    hz = m_stall();
    if (reset) begin
      m_bq.delete(); m_pend = '0; m_wcnt = 0;
    end else begin
      bwr  = !aw && m_bq.size() > 0;
      bacc = b_valid && m_bq.size() == 0;
      if (aw && m_bq.size() > 0 && m_wcnt < LIMIT) m_wcnt++;
      if (bwr) begin m_pend[m_bq[0].a] = 1'b0; void'(m_bq.pop_front()); m_wcnt = 0; end
      if (bacc && b_addr != 0) m_bq.push_back('{b_addr, b_data});
      if (issue_valid && !hz && issue_long && issue_rd != 0) m_pend[issue_rd] = 1'b1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    issue_valid = 0; issue_long = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle();
    @(negedge clk);
    chk_total++; if (b_ready !== 1'b0) $display("FAIL rst_bready got=%b exp=0", b_ready); else chk_pass++;
    chk_total++; if (rf_we !== 1'b0) $display("FAIL rst_we got=%b exp=0", rf_we); else chk_pass++;
    a_valid = 1; a_addr = 3; a_data = 32'hAA; #1;
    chk_total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3) $display("FAIL rst_a_pass we=%b addr=%0d exp=1/3", rf_we, rf_waddr); else chk_pass++;
    tick();
    reset = 0; idle();
    @(negedge clk);
    chk_total++; if (rf_we !== 1'b0) $display("FAIL idle_we got=%b exp=0", rf_we); else chk_pass++;
    chk_total++; if (b_ready !== 1'b1) $display("FAIL idle_bready got=%b exp=1", b_ready); else chk_pass++;
    chk_total++; if (hazard_stall !== 1'b0 || pipe_hold !== 1'b0) $display("FAIL idle_stall_hold got=%b/%b exp=0/0", hazard_stall, pipe_hold); else chk_pass++;
    tick();
    a_valid = 1; a_addr = 5; a_data = 32'h1234;
    @(negedge clk);
    chk_total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234)
      $display("FAIL a_pass got=%b/%0d/%h exp=1/5/1234", rf_we, rf_waddr, rf_wdata); else chk_pass++;
    tick(); idle();
  endtask

  task automatic test_raw();
    issue_valid = 1; issue_long = 1; issue_rd = 7;
    @(negedge clk);
    chk_total++; if (hazard_stall !== 1'b0) $display("FAIL raw_issue got=%b exp=0", hazard_stall); else chk_pass++;
    tick();
    issue_long = 0; issue_rd = 1; rs1_addr = 7;
    @(negedge clk);
    chk_total++; if (hazard_stall !== 1'b1) $display("FAIL raw_stall got=%b exp=1", hazard_stall); else chk_pass++;
    tick();
    b_valid = 1; b_addr = 7; b_data = 32'hDEAD;
    @(negedge clk);
    chk_total++; if (b_ready !== 1'b1) $display("FAIL raw_bready got=%b exp=1", b_ready); else chk_pass++;
    tick();
    b_valid = 0;
    @(negedge clk);
    chk_total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEAD)
      $display("FAIL raw_bwrite got=%b/%0d/%h exp=1/7/dead", rf_we, rf_waddr, rf_wdata); else chk_pass++;
    chk_total++; if (hazard_stall !== 1'b1) $display("FAIL raw_stall_hold got=%b exp=1", hazard_stall); else chk_pass++;
    tick();
    @(negedge clk);
    chk_total++; if (hazard_stall !== 1'b0) $display("FAIL raw_release got=%b exp=0", hazard_stall); else chk_pass++;
    chk_total++; if (rf_mem[7] !== 32'hDEAD) $display("FAIL raw_read got=%h exp=dead", rf_mem[7]); else chk_pass++;
    tick(); idle();
  endtask

  task automatic test_contention();
    b_valid = 1; b_addr = 9; b_data = 32'hBEEF;
    tick();
    idle();
    for (int i = 0; i < 6; i++) begin
      a_valid = 1; a_addr = 5'(i + 1); a_data = $urandom();
      @(negedge clk);
      chk_total++; if (pipe_hold !== (i >= LIMIT)) $display("FAIL cont_hold i=%0d got=%b exp=%b", i, pipe_hold, i >= LIMIT); else chk_pass++;
      chk_total++; if (rf_waddr !== 5'(i + 1)) $display("FAIL cont_awins i=%0d got=%0d exp=%0d", i, rf_waddr, i + 1); else chk_pass++;
      tick();
    end
    idle();
    @(negedge clk);
    chk_total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hBEEF)
      $display("FAIL cont_drain got=%b/%0d/%h exp=1/9/beef", rf_we, rf_waddr, rf_wdata); else chk_pass++;
    tick();
    @(negedge clk);
    chk_total++; if (pipe_hold !== 1'b0 || b_ready !== 1'b1) $display("FAIL cont_after got=%b/%b exp=0/1", pipe_hold, b_ready); else chk_pass++;
    b_valid = 1; b_addr = 10; b_data = 32'h10;
    tick();
    idle(); a_valid = 1; a_addr = 2; a_data = 32'h2;
    tick();
    @(negedge clk);
    chk_total++; if (pipe_hold !== 1'b0) $display("FAIL cont_cnt_clear got=%b exp=0", pipe_hold); else chk_pass++;
    idle();
    tick(); tick();
  endtask

  task automatic test_waw();
    issue_valid = 1; issue_long = 1; issue_rd = 3;
    tick();
    @(negedge clk);
    chk_total++; if (hazard_stall !== 1'b1) $display("FAIL waw_stall got=%b exp=0->1", hazard_stall); else chk_pass++;
    idle(); b_valid = 1; b_addr = 3; b_data = 32'h33;
    tick();
    idle(); tick();
    // x4 result arrives with no outstanding issue, then drains alongside a new long issue to x4.
    b_valid = 1; b_addr = 4; b_data = 32'h44;
    tick();
    idle(); issue_valid = 1; issue_long = 1; issue_rd = 4;
    @(negedge clk);
    chk_total++; if (hazard_stall !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd4)
      $display("FAIL setclr_cycle got=%b/%b/%0d exp=0/1/4", hazard_stall, rf_we, rf_waddr); else chk_pass++;
    tick();
    issue_long = 0; issue_rd = 0; rs1_addr = 4;
    @(negedge clk);
    chk_total++; if (hazard_stall !== 1'b1) $display("FAIL setclr_wins got=%b exp=1", hazard_stall); else chk_pass++;
    idle(); b_valid = 1; b_addr = 4; b_data = 32'h45;
    tick();
    idle(); tick();
  endtask

  task automatic test_x0();
    issue_valid = 1; issue_long = 1; issue_rd = 0;
    tick();
    @(negedge clk);
    chk_total++; if (hazard_stall !== 1'b0) $display("FAIL x0_issue got=%b exp=0", hazard_stall); else chk_pass++;
    idle(); b_valid = 1; b_addr = 0; b_data = 32'hBAD;
    @(negedge clk);
    chk_total++; if (b_ready !== 1'b1) $display("FAIL x0_b_accept got=%b exp=1", b_ready); else chk_pass++;
    tick();
    idle();
    @(negedge clk);
    chk_total++; if (rf_we !== 1'b0 || b_ready !== 1'b1) $display("FAIL x0_b_drop got=%b/%b exp=0/1", rf_we, b_ready); else chk_pass++;
    b_valid = 1; b_addr = 12; b_data = 32'h55;
    tick();
    idle(); a_valid = 1; a_addr = 0; a_data = 32'hFFFF;
    @(negedge clk);
    chk_total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h55)
      $display("FAIL x0_a_drop got=%b/%0d/%h exp=1/12/55", rf_we, rf_waddr, rf_wdata); else chk_pass++;
    tick(); idle();
  endtask

  task automatic test_reset_mid();
    issue_valid = 1; issue_long = 1; issue_rd = 13;
    tick();
    issue_rd = 14;
    tick();
    idle(); b_valid = 1; b_addr = 13; b_data = 32'hC0DE;
    tick();
    idle(); reset = 1;
    @(negedge clk);
    chk_total++; if (rf_we !== 1'b0) $display("FAIL rmid_nowrite got=%b exp=0", rf_we); else chk_pass++;
    tick();
    reset = 0;
    @(negedge clk);
    chk_total++; if (rf_we !== 1'b0 || b_ready !== 1'b1) $display("FAIL rmid_empty got=%b/%b exp=0/1", rf_we, b_ready); else chk_pass++;
    issue_valid = 1; issue_long = 1; issue_rd = 14; rs1_addr = 13; rs2_addr = 14; #1;
    chk_total++; if (hazard_stall !== 1'b0) $display("FAIL rmid_pend_clear got=%b exp=0", hazard_stall); else chk_pass++;
    idle(); tick();
    chk_total++; if (rf_mem[13] === 32'hC0DE) $display("FAIL rmid_stale got=%h exp=not c0de", rf_mem[13]); else chk_pass++;
  endtask

  task automatic test_random();
    bit m_we;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      a_valid = 1'($urandom_range(0, 1));
      // Honour the bubble request most of the time; occasionally violate it.
      if (m_bq.size() > 0 && m_wcnt == LIMIT && $urandom_range(0, 9) != 0) a_valid = 0;
      a_addr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      a_data = $urandom();
      b_valid = 1'($urandom_range(0, 1));
      b_addr = 5'($urandom_range(0, 7)); b_data = $urandom();
      issue_valid = 1'($urandom_range(0, 1)); issue_long = 1'($urandom_range(0, 1));
      issue_rd = 5'($urandom_range(0, 7));
      rs1_addr = 5'($urandom_range(0, 7)); rs2_addr = 5'($urandom_range(0, 7));
      @(negedge clk);
      m_we = (a_valid && a_addr != 0) || (m_bq.size() > 0 && !reset);
      chk_total++; if (b_ready !== (m_bq.size() == 0 && !reset)) $display("FAIL rnd_bready c=%0d got=%b", c, b_ready); else chk_pass++;
      chk_total++; if (rf_we !== m_we) $display("FAIL rnd_we c=%0d got=%b exp=%b", c, rf_we, m_we); else chk_pass++;
      if (m_we) begin
        chk_total++;
        if (a_valid && a_addr != 0) begin
          if (rf_waddr !== a_addr || rf_wdata !== a_data) $display("FAIL rnd_wr_a c=%0d got=%0d/%h exp=%0d/%h", c, rf_waddr, rf_wdata, a_addr, a_data); else chk_pass++;
        end else begin
          if (rf_waddr !== m_bq[0].a || rf_wdata !== m_bq[0].d) $display("FAIL rnd_wr_b c=%0d got=%0d/%h exp=%0d/%h", c, rf_waddr, rf_wdata, m_bq[0].a, m_bq[0].d); else chk_pass++;
        end
      end
      chk_total++; if (hazard_stall !== m_stall()) $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, hazard_stall, m_stall()); else chk_pass++;
      chk_total++; if (pipe_hold !== (m_bq.size() > 0 && m_wcnt == LIMIT)) $display("FAIL rnd_hold c=%0d got=%b", c, pipe_hold); else chk_pass++;
      tick();
    end
    reset = 0; idle();
  endtask

  initial begin
    m_pend = '0; m_wcnt = 0;
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    test_reset();
    test_raw();
    test_contention();
    test_waw();
    test_x0();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end
endmodule
